// File: rtl/pipeline_spi_pkg.sv
// Shared constants for the SPI control register file: opcodes, special
// command bytes, frame-parser state encoding and per-opcode argument count.
package pipeline_spi_pkg;

    localparam logic [3:0] OP_RESET    = 4'd0;
    localparam logic [3:0] OP_MODE     = 4'd1;
    localparam logic [3:0] OP_FLAGS    = 4'd2;
    localparam logic [3:0] OP_SCALE    = 4'd3;
    localparam logic [3:0] OP_OFFSET_X = 4'd4;
    localparam logic [3:0] OP_OFFSET_Y = 4'd5;
    localparam logic [3:0] OP_TRANSP   = 4'd6;
    localparam logic [3:0] OP_CLIP_L   = 4'd7;
    localparam logic [3:0] OP_CLIP_R   = 4'd8;
    localparam logic [3:0] OP_CLIP_T   = 4'd9;
    localparam logic [3:0] OP_CLIP_B   = 4'd10;
    localparam logic [3:0] OP_FREEZE   = 4'd11;
    localparam logic [3:0] OP_READ     = 4'd13;

    localparam logic [7:0] CMD_NO_OP        = 8'hFF;
    localparam logic [7:0] CMD_GLOBAL_RESET = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARG1  = 2'd1,
        ST_ARG2  = 2'd2,
        ST_APPLY = 2'd3
    } state_e;

    // Number of argument bytes following a command byte; unknown opcodes take none.
    function automatic logic [1:0] arg_count(input logic [3:0] op);
        case (op)
            OP_MODE, OP_FLAGS, OP_SCALE, OP_TRANSP, OP_FREEZE, OP_READ: return 2'd1;
            OP_OFFSET_X, OP_OFFSET_Y,
            OP_CLIP_L, OP_CLIP_R, OP_CLIP_T, OP_CLIP_B:                 return 2'd2;
            default:                                                    return 2'd0;
        endcase
    endfunction

    // Opcodes 12, 14 and 15 are undefined.
    function automatic logic op_known(input logic [3:0] op);
        return !((op == 4'd12) || (op == 4'd14) || (op == 4'd15));
    endfunction

    function automatic logic layer_ok(input logic [3:0] layer, input int num_layers);
        return int'(layer) < num_layers;
    endfunction

endpackage

// File: rtl/pipeline_spi_layer_regs.sv
// One foreground layer's control registers. With SPI_SHADOW_COMMIT_EN the
// written set is a shadow copied to the live outputs on commit_i; without
// it the written set drives the outputs directly. Readback always returns
// the written set.
module pipeline_spi_layer_regs
    import pipeline_spi_pkg::*;
#(
    parameter int PRECISION = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic                 clear_i,
    input  logic [3:0]           op_i,
    input  logic [PRECISION:0]   arg_i,
`ifdef SPI_SHADOW_COMMIT_EN
    input  logic                 commit_i,
`endif
    input  logic [3:0]           rd_op_i,
    output logic [15:0]          rd_data_o,
    output logic [1:0]           mode_o,
    output logic [1:0]           scale_o,
    output logic [PRECISION:0]   offset_x_o,
    output logic [PRECISION:0]   offset_y_o,
    output logic [PRECISION-1:0] clip_left_o,
    output logic [PRECISION-1:0] clip_right_o,
    output logic [PRECISION-1:0] clip_top_o,
    output logic [PRECISION-1:0] clip_bottom_o
);

    logic [1:0]           mode_q, mode_d, scale_q, scale_d;
    logic [PRECISION:0]   offx_q, offx_d, offy_q, offy_d;
    logic [PRECISION-1:0] cl_q, cl_d, cr_q, cr_d, ct_q, ct_d, cb_q, cb_d;

    // Next value of the written set: clear, layer reset, or a field write.
    always_comb begin
        mode_d = mode_q; scale_d = scale_q; offx_d = offx_q; offy_d = offy_q;
        cl_d = cl_q; cr_d = cr_q; ct_d = ct_q; cb_d = cb_q;
        if (clear_i || (we_i && op_i == OP_RESET)) begin
            mode_d = '0; scale_d = '0; offx_d = '0; offy_d = '0;
            cl_d = '0; cr_d = '0; ct_d = '0; cb_d = '0;
        end else if (we_i) begin
            case (op_i)
                OP_MODE:     mode_d = arg_i[1:0];
                OP_SCALE:    scale_d = arg_i[1:0];
                OP_OFFSET_X: offx_d = arg_i;
                OP_OFFSET_Y: offy_d = arg_i;
                OP_CLIP_L:   cl_d = arg_i[PRECISION-1:0];
                OP_CLIP_R:   cr_d = arg_i[PRECISION-1:0];
                OP_CLIP_T:   ct_d = arg_i[PRECISION-1:0];
                OP_CLIP_B:   cb_d = arg_i[PRECISION-1:0];
                default:     ;
            endcase
        end
    end

    // Written-set registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0; scale_q <= '0; offx_q <= '0; offy_q <= '0;
            cl_q <= '0; cr_q <= '0; ct_q <= '0; cb_q <= '0;
        end else begin
            mode_q <= mode_d; scale_q <= scale_d; offx_q <= offx_d; offy_q <= offy_d;
            cl_q <= cl_d; cr_q <= cr_d; ct_q <= ct_d; cb_q <= cb_d;
        end
    end

    // Readback mux, zero-extended to 16 bits.
    always_comb begin
        case (rd_op_i)
            OP_MODE:     rd_data_o = 16'(mode_q);
            OP_SCALE:    rd_data_o = 16'(scale_q);
            OP_OFFSET_X: rd_data_o = 16'(offx_q);
            OP_OFFSET_Y: rd_data_o = 16'(offy_q);
            OP_CLIP_L:   rd_data_o = 16'(cl_q);
            OP_CLIP_R:   rd_data_o = 16'(cr_q);
            OP_CLIP_T:   rd_data_o = 16'(ct_q);
            OP_CLIP_B:   rd_data_o = 16'(cb_q);
            default:     rd_data_o = 16'h0000;
        endcase
    end

`ifdef SPI_SHADOW_COMMIT_EN
    logic [1:0]           live_mode_q, live_scale_q;
    logic [PRECISION:0]   live_offx_q, live_offy_q;
    logic [PRECISION-1:0] live_cl_q, live_cr_q, live_ct_q, live_cb_q;

    // Live copy: cleared with the shadow, otherwise loaded at frame commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || 1'b0) begin
            live_mode_q <= '0; live_scale_q <= '0; live_offx_q <= '0; live_offy_q <= '0;
            live_cl_q <= '0; live_cr_q <= '0; live_ct_q <= '0; live_cb_q <= '0;
        end else if (clear_i) begin
            live_mode_q <= '0; live_scale_q <= '0; live_offx_q <= '0; live_offy_q <= '0;
            live_cl_q <= '0; live_cr_q <= '0; live_ct_q <= '0; live_cb_q <= '0;
        end else if (commit_i) begin
            live_mode_q <= mode_q; live_scale_q <= scale_q;
            live_offx_q <= offx_q; live_offy_q <= offy_q;
            live_cl_q <= cl_q; live_cr_q <= cr_q; live_ct_q <= ct_q; live_cb_q <= cb_q;
        end
    end

    assign mode_o = live_mode_q;   assign scale_o = live_scale_q;
    assign offset_x_o = live_offx_q; assign offset_y_o = live_offy_q;
    assign clip_left_o = live_cl_q;  assign clip_right_o = live_cr_q;
    assign clip_top_o = live_ct_q;   assign clip_bottom_o = live_cb_q;
`else
    assign mode_o = mode_q;   assign scale_o = scale_q;
    assign offset_x_o = offx_q; assign offset_y_o = offy_q;
    assign clip_left_o = cl_q;  assign clip_right_o = cr_q;
    assign clip_top_o = ct_q;   assign clip_bottom_o = cb_q;
`endif

endmodule

// File: rtl/pipeline_spi_regfile.sv
// Framed SPI command decoder and per-layer control register file.
// Frames are {layer, opcode} followed by 0..2 argument bytes (MSB first).
// READ returns a 16-bit value over two tx_load strobes. Optional macro
// SPI_SHADOW_COMMIT_EN adds frame_commit and shadowed writes.
// Handshake: byte_valid is a one-cycle strobe with no back-pressure; every
// strobe while spi_active is high is consumed, including one landing in APPLY.
module pipeline_spi_regfile
    import pipeline_spi_pkg::*;
#(
    parameter int PRECISION  = 11,
    parameter int NUM_LAYERS = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                spi_active,
    input  logic [7:0]                          byte_in,
    input  logic                                byte_valid,
`ifdef SPI_SHADOW_COMMIT_EN
    input  logic                                frame_commit,
`endif
    output logic [7:0]                          tx_byte,
    output logic                                tx_load,
    output logic                                cmd_error,
    output logic [2*NUM_LAYERS-1:0]             ctrl_overlay_mode,
    output logic [2*NUM_LAYERS-1:0]             ctrl_fg_scale,
    output logic [(PRECISION+1)*NUM_LAYERS-1:0] ctrl_fg_offset_x,
    output logic [(PRECISION+1)*NUM_LAYERS-1:0] ctrl_fg_offset_y,
    output logic [PRECISION*NUM_LAYERS-1:0]     ctrl_fg_clip_left,
    output logic [PRECISION*NUM_LAYERS-1:0]     ctrl_fg_clip_right,
    output logic [PRECISION*NUM_LAYERS-1:0]     ctrl_fg_clip_top,
    output logic [PRECISION*NUM_LAYERS-1:0]     ctrl_fg_clip_bottom
);

    localparam int ARG_W = PRECISION + 1;

    state_e           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [ARG_W-1:0] arg_q, arg_d;
    logic             frame_done;
    logic [7:0]       tx_byte_q, tx_byte_d, rd_lo_q, rd_lo_d;
    logic             tx_load_q, tx_load_d, rd_pend_q, rd_pend_d;
    logic             cmd_error_q, cmd_error_d;
    logic             special_d, frame_bad, frame_read;
    logic             apply_ok, global_clr;
    logic [15:0]      rd_sel;
    logic [15:0]      rd_data [NUM_LAYERS];

    // Frame parser: tracks which byte of the current frame is expected.
    always_comb begin
        state_d = state_q; cmd_d = cmd_q; arg_d = arg_q; frame_done = 1'b0;
        if (!spi_active) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_APPLY: begin
                    state_d = ST_IDLE;
                    if (byte_valid) begin
                        cmd_d = byte_in;
                        if (arg_count(byte_in[3:0]) == 2'd0) begin
                            state_d = ST_APPLY; frame_done = 1'b1;
                        end else begin
                            state_d = ST_ARG1;
                        end
                    end
                end
                ST_ARG1: if (byte_valid) begin
                    arg_d = ARG_W'(byte_in);
                    if (arg_count(cmd_q[3:0]) == 2'd1) begin
                        state_d = ST_APPLY; frame_done = 1'b1;
                    end else begin
                        state_d = ST_ARG2;
                    end
                end
                ST_ARG2: if (byte_valid) begin
                    arg_d = ARG_W'({arg_q[7:0], byte_in});
                    state_d = ST_APPLY; frame_done = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Read source: layer from the latched command, target opcode is the arriving argument.
    always_comb begin
        rd_sel = 16'h0000;
        for (int i = 0; i < NUM_LAYERS; i++)
            if (cmd_q[7:4] == 4'(i)) rd_sel = rd_data[i];
    end

    // Error and readback strobes, registered so they are high during APPLY.
    always_comb begin
        special_d  = (cmd_d == CMD_NO_OP) || (cmd_d == CMD_GLOBAL_RESET);
        frame_bad  = frame_done && !special_d &&
                     (!op_known(cmd_d[3:0]) || !layer_ok(cmd_d[7:4], NUM_LAYERS));
        frame_read = frame_done && !special_d && !frame_bad && (cmd_d[3:0] == OP_READ);
        cmd_error_d = frame_bad;
        tx_byte_d = tx_byte_q; tx_load_d = 1'b0; rd_lo_d = rd_lo_q; rd_pend_d = rd_pend_q;
        if (frame_read) begin
            tx_byte_d = rd_sel[15:8]; tx_load_d = 1'b1;
            rd_lo_d   = rd_sel[7:0];  rd_pend_d = 1'b1;
        end else if (spi_active && byte_valid && rd_pend_q) begin
            tx_byte_d = rd_lo_q; tx_load_d = 1'b1; rd_pend_d = 1'b0;
        end
    end

    // Decoder state and output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE; cmd_q <= '0; arg_q <= '0;
            tx_byte_q <= '0; tx_load_q <= 1'b0; rd_lo_q <= '0; rd_pend_q <= 1'b0;
            cmd_error_q <= 1'b0;
        end else begin
            state_q <= state_d; cmd_q <= cmd_d; arg_q <= arg_d;
            tx_byte_q <= tx_byte_d; tx_load_q <= tx_load_d;
            rd_lo_q <= rd_lo_d; rd_pend_q <= rd_pend_d;
            cmd_error_q <= cmd_error_d;
        end
    end

    assign tx_byte   = tx_byte_q;
    assign tx_load   = tx_load_q;
    assign cmd_error = cmd_error_q;

    // APPLY: commit a well-formed frame to its layer, or clear every layer.
    assign apply_ok   = (state_q == ST_APPLY) && (cmd_q != CMD_NO_OP) &&
                        (cmd_q != CMD_GLOBAL_RESET) && op_known(cmd_q[3:0]) &&
                        layer_ok(cmd_q[7:4], NUM_LAYERS);
    assign global_clr = (state_q == ST_APPLY) && (cmd_q == CMD_GLOBAL_RESET);

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
        pipeline_spi_layer_regs #(.PRECISION(PRECISION)) u_regs (
            .clk           (clk),
            .rst_n         (rst_n),
            .we_i          (apply_ok && (cmd_q[7:4] == 4'(i))),
            .clear_i       (global_clr),
            .op_i          (cmd_q[3:0]),
            .arg_i         (arg_q),
`ifdef SPI_SHADOW_COMMIT_EN
            .commit_i      (frame_commit),
`endif
            .rd_op_i       (byte_in[3:0]),
            .rd_data_o     (rd_data[i]),
            .mode_o        (ctrl_overlay_mode[2*i +: 2]),
            .scale_o       (ctrl_fg_scale[2*i +: 2]),
            .offset_x_o    (ctrl_fg_offset_x[(PRECISION+1)*i +: PRECISION+1]),
            .offset_y_o    (ctrl_fg_offset_y[(PRECISION+1)*i +: PRECISION+1]),
            .clip_left_o   (ctrl_fg_clip_left[PRECISION*i +: PRECISION]),
            .clip_right_o  (ctrl_fg_clip_right[PRECISION*i +: PRECISION]),
            .clip_top_o    (ctrl_fg_clip_top[PRECISION*i +: PRECISION]),
            .clip_bottom_o (ctrl_fg_clip_bottom[PRECISION*i +: PRECISION])
        );
    end

endmodule

// File: tb/tb_pipeline_spi_regfile.sv
// Directed bench for pipeline_spi_regfile (PRECISION=11, NUM_LAYERS=2).
module tb_pipeline_spi_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_active = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
`ifdef SPI_SHADOW_COMMIT_EN
    logic        frame_commit = 1'b0;
`endif
    logic [7:0]  tx_byte;
    logic        tx_load, cmd_error;
    logic [3:0]  mode, scale;
    logic [23:0] offx, offy;
    logic [21:0] clip_l, clip_r, clip_t, clip_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_spi_regfile #(.PRECISION(11), .NUM_LAYERS(2)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .spi_active          (spi_active),
        .byte_in             (byte_in),
        .byte_valid          (byte_valid),
`ifdef SPI_SHADOW_COMMIT_EN
        .frame_commit        (frame_commit),
`endif
        .tx_byte             (tx_byte),
        .tx_load             (tx_load),
        .cmd_error           (cmd_error),
        .ctrl_overlay_mode   (mode),
        .ctrl_fg_scale       (scale),
        .ctrl_fg_offset_x    (offx),
        .ctrl_fg_offset_y    (offy),
        .ctrl_fg_clip_left   (clip_l),
        .ctrl_fg_clip_right  (clip_r),
        .ctrl_fg_clip_top    (clip_t),
        .ctrl_fg_clip_bottom (clip_b)
    );

    // One-cycle byte strobe; returns on the falling edge after it was sampled.
    task automatic send_byte(input logic [7:0] b);
        byte_in = b; byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        idle(2);
        checks++;
        if ({mode, scale, offx, offy, clip_l, clip_r, clip_t, clip_b} !== '0) begin
            errors++; $display("FAIL reset_ctrl: got nonzero ctrl outputs, required all 0");
        end
        checks++;
        if ({tx_byte, tx_load, cmd_error} !== 10'd0) begin
            errors++; $display("FAIL reset_tx: got tx_byte=%h tx_load=%b cmd_error=%b, required 0", tx_byte, tx_load, cmd_error);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_offset();
        send_byte(8'h04); send_byte(8'h01); send_byte(8'h23);
        checks++;
        if (offx !== 24'h000000) begin
            errors++; $display("FAIL offx_latency: got %h in APPLY, required 000000", offx);
        end
        idle(1);
        checks++;
        if (offx !== 24'h000123) begin
            errors++; $display("FAIL offx_write: got %h, required 000123", offx);
        end
        checks++;
        if ({mode, scale, offy, clip_l, clip_r, clip_t, clip_b} !== '0) begin
            errors++; $display("FAIL offx_others: other ctrl outputs nonzero, required 0");
        end
    endtask

    task automatic test_layer_clip();
        send_byte(8'h17); send_byte(8'h02); send_byte(8'h80);
        idle(1);
        checks++;
        if (clip_l !== {11'h280, 11'h000}) begin
            errors++; $display("FAIL clip_layer1: got %h, required %h", clip_l, {11'h280, 11'h000});
        end
        idle(1);
        send_byte(8'h27); send_byte(8'h00); send_byte(8'h05);
        checks++;
        if (cmd_error !== 1'b1) begin
            errors++; $display("FAIL bad_layer_err: got cmd_error=%b, required 1", cmd_error);
        end
        idle(1);
        checks++;
        if (cmd_error !== 1'b0) begin
            errors++; $display("FAIL err_pulse_width: got cmd_error=%b, required 0", cmd_error);
        end
        checks++;
        if (clip_l !== {11'h280, 11'h000} || offx !== 24'h000123) begin
            errors++; $display("FAIL bad_layer_nochange: got clip_l=%h offx=%h", clip_l, offx);
        end
    endtask

    task automatic test_unknown_opcode();
        send_byte(8'h0C);
        checks++;
        if (cmd_error !== 1'b1) begin
            errors++; $display("FAIL unknown_op_err: got cmd_error=%b, required 1", cmd_error);
        end
        send_byte(8'h01); send_byte(8'h02);
        idle(1);
        checks++;
        if (mode !== 4'h2) begin
            errors++; $display("FAIL after_unknown_mode: got %h, required 2", mode);
        end
    endtask

    task automatic test_abort();
        send_byte(8'h04); send_byte(8'h01);
        spi_active = 1'b0;
        idle(1);
        spi_active = 1'b1;
        send_byte(8'h01); send_byte(8'h03);
        idle(1);
        checks++;
        if (offx !== 24'h000123) begin
            errors++; $display("FAIL abort_offx: got %h, required 000123", offx);
        end
        checks++;
        if (mode !== 4'h3) begin
            errors++; $display("FAIL abort_mode: got %h, required 3", mode);
        end
    endtask

    task automatic test_width();
        send_byte(8'h03); send_byte(8'hFE);
        idle(1);
        checks++;
        if (scale !== 4'h2) begin
            errors++; $display("FAIL scale_trunc: got %h, required 2", scale);
        end
        send_byte(8'h15); send_byte(8'hF8); send_byte(8'h01);
        idle(1);
        checks++;
        if (offy !== {12'h801, 12'h000}) begin
            errors++; $display("FAIL offy_trunc: got %h, required 801000", offy);
        end
    endtask

    task automatic test_read();
        send_byte(8'h09); send_byte(8'h01); send_byte(8'hAB);
        idle(1);
        checks++;
        if (clip_t !== {11'h000, 11'h1AB}) begin
            errors++; $display("FAIL clip_top_write: got %h, required 0001ab", clip_t);
        end
        send_byte(8'h0D); send_byte(8'h09);
        checks++;
        if (tx_load !== 1'b1 || tx_byte !== 8'h01) begin
            errors++; $display("FAIL read_hi: got tx_load=%b tx_byte=%h, required 1/01", tx_load, tx_byte);
        end
        idle(1);
        checks++;
        if (tx_load !== 1'b0) begin
            errors++; $display("FAIL read_load_pulse: got tx_load=%b, required 0", tx_load);
        end
        send_byte(8'hFF);
        checks++;
        if (tx_load !== 1'b1 || tx_byte !== 8'hAB) begin
            errors++; $display("FAIL read_lo: got tx_load=%b tx_byte=%h, required 1/ab", tx_load, tx_byte);
        end
        checks++;
        if (cmd_error !== 1'b0) begin
            errors++; $display("FAIL noop_err: got cmd_error=%b, required 0", cmd_error);
        end
        idle(1);
        send_byte(8'h1D); send_byte(8'h05);
        checks++;
        if (tx_load !== 1'b1 || tx_byte !== 8'h08) begin
            errors++; $display("FAIL read_offy_hi: got tx_load=%b tx_byte=%h, required 1/08", tx_load, tx_byte);
        end
        idle(1);
        send_byte(8'hFF);
        checks++;
        if (tx_byte !== 8'h01) begin
            errors++; $display("FAIL read_offy_lo: got tx_byte=%h, required 01", tx_byte);
        end
        idle(1);
        send_byte(8'h2D); send_byte(8'h04);
        checks++;
        if (cmd_error !== 1'b1 || tx_load !== 1'b0) begin
            errors++; $display("FAIL read_bad_layer: got cmd_error=%b tx_load=%b, required 1/0", cmd_error, tx_load);
        end
        idle(1);
    endtask

    task automatic test_global_reset();
        send_byte(8'hFF);
        idle(1);
        checks++;
        if (mode !== 4'h3 || clip_l !== {11'h280, 11'h000} || cmd_error !== 1'b0) begin
            errors++; $display("FAIL noop_nochange: got mode=%h clip_l=%h cmd_error=%b", mode, clip_l, cmd_error);
        end
        send_byte(8'hF0);
        checks++;
        if (cmd_error !== 1'b0) begin
            errors++; $display("FAIL global_err: got cmd_error=%b, required 0", cmd_error);
        end
        idle(1);
        checks++;
        if ({mode, scale, offx, offy, clip_l, clip_r, clip_t, clip_b} !== '0) begin
            errors++; $display("FAIL global_reset: got mode=%h offx=%h offy=%h clip_l=%h clip_t=%h, required 0", mode, offx, offy, clip_l, clip_t);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4];
        seq[0] = 8'h01; seq[1] = 8'h01; seq[2] = 8'h03; seq[3] = 8'h02;
        byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            byte_in = seq[i];
            @(negedge clk);
        end
        byte_valid = 1'b0;
        idle(1);
        checks++;
        if (mode !== 4'h1 || scale !== 4'h2) begin
            errors++; $display("FAIL back_to_back: got mode=%h scale=%h, required 1/2", mode, scale);
        end
    endtask

`ifdef SPI_SHADOW_COMMIT_EN
    task automatic test_shadow();
        send_byte(8'h01); send_byte(8'h02);
        idle(3);
        checks++;
        if (mode !== 4'h0) begin
            errors++; $display("FAIL shadow_hold: got %h, required 0", mode);
        end
        frame_commit = 1'b1;
        idle(1);
        frame_commit = 1'b0;
        checks++;
        if (mode !== 4'h2) begin
            errors++; $display("FAIL shadow_commit: got %h, required 2", mode);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SPI_SHADOW_COMMIT_EN
        test_shadow();
`else
        test_offset();
        test_layer_clip();
        test_unknown_opcode();
        test_abort();
        test_width();
        test_read();
        test_global_reset();
        test_back_to_back();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_spi_regfile.md
Name: pipeline_spi_regfile

Overview:
- Multi-layer successor to the single-foreground SPI control decoder.
- Consumes the byte stream from the existing spi_slave and decodes framed commands addressed to one of NUM_LAYERS foreground layers. Holds the per-layer control registers that drive the pipeline.
- Adds register readback over MISO and an error pulse for malformed frames.
- Sits between spi_slave and the pipeline compositor.

Parameters:
- PRECISION, 11: coordinate width. Clips are PRECISION bits; offsets are signed PRECISION+1 bits.
- NUM_LAYERS, 2: number of foreground layers, 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spi_active  in  1  high while slave-select is asserted
- byte_in  in  8  received byte from spi_slave
- byte_valid  in  1  one-cycle strobe, byte_in valid
- tx_byte  out  8  byte for spi_slave to shift out on the next transfer
- tx_load  out  1  one-cycle strobe, tx_byte updated
- cmd_error  out  1  one-cycle pulse on an unknown opcode or an out-of-range layer
- ctrl_overlay_mode  out  2*NUM_LAYERS  per-layer mode; layer i at [2i+1:2i]
- ctrl_fg_scale  out  2*NUM_LAYERS  per-layer scale, same packing
- ctrl_fg_offset_x, ctrl_fg_offset_y  out  (PRECISION+1)*NUM_LAYERS  signed per-layer offsets
- ctrl_fg_clip_left/right/top/bottom  out  PRECISION*NUM_LAYERS  per-layer clips

Behaviour:
- Reset: async on rst_n low. All ctrl outputs 0, tx_byte 0x00, tx_load 0, cmd_error 0, state IDLE.
- Command byte format is {layer[7:4], opcode[3:0]}.
- Opcodes:
  - 0 RESET: no argument.
  - 1 MODE, 2 FLAGS, 3 SCALE, 6 TRANSPARENCY, 11 FREEZE: 1 argument byte.
  - 4 OFFSET_X, 5 OFFSET_Y, 7-10 CLIP L/R/T/B: 2 argument bytes, MSB first.
  - 13 READ: 1 argument byte, which is the target opcode.
  - Opcodes 2, 6 and 11 are accepted and consumed without effect.
- Special command bytes:
  - 0xFF is NO_OP.
  - 0xF0 is GLOBAL RESET: zeroes all layers.
- States:
  - IDLE: byte_valid latches the command. 0-argument commands go to APPLY; all others go to ARG1.
  - ARG1: byte_valid latches arg[7:0]. 1-argument commands go to APPLY; 2-argument commands go to ARG2.
  - ARG2: byte_valid sets arg = {arg[7:0], byte_in}, then goes to APPLY.
  - APPLY: lasts one cycle and always returns to IDLE.
- APPLY actions:
  - Write commands update the register. The output changes on the clock edge ending APPLY, i.e. 2 clk after the final byte_valid.
  - READ loads the selected value, zero-extended to 16 bits, with MSB first:
    - tx_byte = value[15:8] with a tx_load pulse in APPLY.
    - tx_byte = value[7:0] with a tx_load pulse on the next byte_valid.
- Width rules:
  - Offsets take arg[PRECISION:0].
  - Clips take arg[PRECISION-1:0].
  - Mode and scale take arg[1:0].
  - Higher argument bits are ignored.
- Out-of-range layer (layer >= NUM_LAYERS, excluding 0xF0 and 0xFF) or unknown opcode (12, 14, 15):
  - Arguments are still consumed according to the opcode; unknown opcodes take 0 arguments.
  - No register changes.
  - cmd_error pulses in APPLY.
- spi_active low:
  - Forces IDLE immediately and discards any partial frame; no register changes.
  - Takes priority over byte_valid in the same cycle.
- A byte_valid arriving while in APPLY is taken as the next command byte, so no bytes are lost.

Optional Feature:
- Macro: SPI_SHADOW_COMMIT_EN.
- With the macro defined:
  - Adds input frame_commit (1 bit, pulse at vsync).
  - Writes go to shadow registers, which are copied to the ctrl outputs on the cycle after frame_commit.
  - GLOBAL RESET clears both shadow and live registers immediately.
  - READ returns the shadow value.
- Without the macro: no frame_commit port; writes reach the outputs directly as above.

Decomposition:
- Shared package pipeline_spi_pkg holds:
  - opcode constants;
  - state encodings;
  - the NO_OP and GLOBAL RESET byte constants;
  - a function returning the argument count for an opcode.
- One sub-module: pipeline_spi_layer_regs, instantiated NUM_LAYERS times via generate. It holds one layer's registers plus shadow, and has inputs for write enable, opcode, argument and commit.

Test Plan:
- Reset, then bytes 0x04, 0x01, 0x23 -> ctrl_fg_offset_x layer0 = 0x123 (11:0) two cycles after the last byte; all other outputs remain 0.
- Bytes 0x17, 0x02, 0x80 with NUM_LAYERS=2 -> layer1 clip_left = 0x280; layer0 unchanged. Then 0x27, 0x00, 0x05 -> cmd_error pulse, no change.
- Bytes 0x04, 0x01, then spi_active drops, then 0x01, 0x03 -> offset_x unchanged; layer0 mode = 3.
- Write layer0 clip_top = 0x1AB, then 0x0D, 0x09 -> tx_byte 0x01 with tx_load, then 0xAB on the next byte_valid.
- Program both layers, send 0xF0 -> every ctrl output 0; 0xFF -> no change and no cmd_error.
- With SPI_SHADOW_COMMIT_EN: write mode = 2 -> output stays 0 until a frame_commit pulse, then reads 2.
